// File: rtl/gf_add_accum.sv
// rtl/gf_add_accum.sv - streaming integer + GF(2^WIDTH) burst accumulator
//
// Purpose: accumulates a and b over a burst (closed by in_last or by MAX_LEN
// beats). It keeps two running results: the integer sum mod 2^WIDTH with a
// sticky wrap flag, and the GF(2^WIDTH) sum, which is a bitwise XOR. Each burst
// result is presented through a registered valid/ready output stage.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   in_a, in_b, in_last   operands and end-of-burst marker
//   out_valid / out_ready result handshake
//   out_sum, out_gf       integer and GF sums of the burst
//   out_ovf               integer sum wrapped at least once
//   out_count             beats in the burst
//   out_trunc             burst closed by MAX_LEN without in_last
module gf_add_accum #(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 16,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_gf,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] acc_gf;
    logic             acc_ovf;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic             close;
    logic             hit_max;
    logic [WIDTH-1:0] base_sum;
    logic [WIDTH-1:0] base_gf;
    logic             base_ovf;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH+1:0] sum_wide;
    logic [WIDTH-1:0] new_sum;
    logic [WIDTH-1:0] new_gf;
    logic             new_ovf;
    logic [CNT_W-1:0] new_cnt;

    // Stall only while a result is held and the consumer is not taking it.
    // A closing beat can therefore land in the same cycle as a drain.
    assign in_ready = !(out_valid && !out_ready);
    assign beat     = in_valid && in_ready;

    always_comb begin
        // A burst that opens in IDLE starts from zero.
        if (state == IDLE) begin
            base_sum = '0;
            base_gf  = '0;
            base_ovf = 1'b0;
            base_cnt = '0;
        end else begin
            base_sum = acc_sum;
            base_gf  = acc_gf;
            base_ovf = acc_ovf;
            base_cnt = cnt;
        end

        // Two guard bits: the sum of three WIDTH-bit terms can carry by up to 2.
        sum_wide = {2'b00, base_sum} + {2'b00, in_a} + {2'b00, in_b};
        new_sum  = sum_wide[WIDTH-1:0];
        new_ovf  = base_ovf | (sum_wide[WIDTH+1:WIDTH] != 2'b00);
        new_gf   = base_gf ^ in_a ^ in_b;
        new_cnt  = base_cnt + CNT_W'(1);
        hit_max  = (new_cnt == CNT_W'(MAX_LEN));
        close    = beat && (in_last || hit_max);
    end

    always_comb begin
        state_next = state;
        if (beat) begin
            state_next = close ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
            acc_gf  <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else if (beat) begin
            if (close) begin
                acc_sum <= '0;
                acc_gf  <= '0;
                acc_ovf <= 1'b0;
                cnt     <= '0;
            end else begin
                acc_sum <= new_sum;
                acc_gf  <= new_gf;
                acc_ovf <= new_ovf;
                cnt     <= new_cnt;
            end
        end
    end

    // Output registers load only on a close; otherwise they hold, which keeps
    // them stable while the consumer applies backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_gf    <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= new_sum;
            out_gf    <= new_gf;
            out_ovf   <= new_ovf;
            out_count <= new_cnt;
            out_trunc <= hit_max && !in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf_add_accum.sv
// tb/tb_gf_add_accum.sv - self-checking bench for gf_add_accum
module tb_gf_add_accum;

    localparam int WIDTH   = 32;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_gf;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    gf_add_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_gf    (out_gf),
        .out_ovf   (out_ovf),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] gf;
        logic             ovf;
        int               count;
        logic             trunc;
    } result_t;

    // Reference model: the burst is kept as a list of operands and reduced
    // with unbounded arithmetic when it closes.
    logic [WIDTH-1:0] beat_a[$];
    logic [WIDTH-1:0] beat_b[$];
    result_t          exp_q[$];
    int               valid_cycles = 0;
    logic             hold = 1'b0;
    logic [WIDTH-1:0] prev_sum, prev_gf;
    logic             prev_ovf, prev_trunc;
    logic [CNT_W-1:0] prev_count;

    function automatic result_t reduce_burst(input logic last);
        result_t r;
        longint unsigned total;
        logic [WIDTH-1:0] x;
        total = 0;
        x     = '0;
        foreach (beat_a[i]) begin
            total += longint'(beat_a[i]) + longint'(beat_b[i]);
            x     ^= beat_a[i] ^ beat_b[i];
        end
        r.sum   = total[WIDTH-1:0];
        r.gf    = x;
        r.ovf   = (total >= (64'd1 << WIDTH));
        r.count = beat_a.size();
        r.trunc = !last && (beat_a.size() == MAX_LEN);
        return r;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_a.delete();
            beat_b.delete();
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_sum",   out_sum,   prev_sum);
                check("hold_gf",    out_gf,    prev_gf);
                check("hold_ovf",   out_ovf,   prev_ovf);
                check("hold_count", out_count, prev_count);
                check("hold_trunc", out_trunc, prev_trunc);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid) begin
                valid_cycles++;
                check("sb_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("sb_sum",   out_sum,   exp_q[0].sum);
                    check("sb_gf",    out_gf,    exp_q[0].gf);
                    check("sb_ovf",   out_ovf,   exp_q[0].ovf);
                    check("sb_count", out_count, exp_q[0].count);
                    check("sb_trunc", out_trunc, exp_q[0].trunc);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            hold       = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_gf    = out_gf;
            prev_ovf   = out_ovf;
            prev_count = out_count;
            prev_trunc = out_trunc;
            if (in_valid && in_ready) begin
                beat_a.push_back(in_a);
                beat_b.push_back(in_b);
                if (in_last || beat_a.size() == MAX_LEN) begin
                    exp_q.push_back(reduce_burst(in_last));
                    beat_a.delete();
                    beat_b.delete();
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 ns after the
    // accepting edge with in_valid low.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", ok, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [WIDTH-1:0] sum,
                                 input logic [WIDTH-1:0] gf, input logic ovf,
                                 input int count, input logic trunc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"},   out_sum,   sum);
        check({tag, "_gf"},    out_gf,    gf);
        check({tag, "_ovf"},   out_ovf,   ovf);
        check({tag, "_count"}, out_count, count);
        check({tag, "_trunc"}, out_trunc, trunc);
    endtask

    initial begin
        int  v0;
        bit  acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_count", out_count, 0);
        @(posedge clk);
        #1;

        send(32'd10, 32'd25, 1'b1);
        expect_result("single1", 32'd35, 32'd19, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;
        send(32'd28, 32'd72, 1'b1);
        expect_result("single2", 32'd100, 32'd84, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        v0 = valid_cycles;
        send(32'd10, 32'd25, 1'b0);
        send(32'd28, 32'd72, 1'b0);
        send(32'd1,  32'd2,  1'b1);
        expect_result("burst3", 32'd138, 32'd68, 1'b0, 3, 1'b0);
        repeat (2) @(negedge clk);
        check("burst3_valid_once", valid_cycles - v0, 1);
        @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'd1, 1'b1);
        expect_result("ovf", 32'd0, 32'hFFFF_FFFE, 1'b1, 1, 1'b0);
        @(posedge clk);
        #1;
        send(32'd1, 32'd1, 1'b1);
        expect_result("ovf_clear", 32'd2, 32'd0, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) send(32'd1, 32'd1, 1'b0);
        expect_result("trunc", 32'd8, 32'd0, 1'b0, 4, 1'b1);
        @(posedge clk);
        #1;
        send(32'd1, 32'd1, 1'b1);
        expect_result("after_trunc", 32'd2, 32'd0, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        // Backpressure: result held, next beat stalls until the drain cycle.
        out_ready = 1'b0;
        send(32'd10, 32'd25, 1'b1);
        expect_result("bp_old", 32'd35, 32'd19, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 32'd2;
        in_b     = 32'd3;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_result("bp_new", 32'd5, 32'd1, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-burst.
        send(32'd5, 32'd5, 1'b0);
        send(32'd5, 32'd5, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_sum",   out_sum,   0);
        check("mid_rst_gf",    out_gf,    0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_ovf",   {out_ovf, out_trunc}, 2'b00);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd3, 32'd4, 1'b1);
        expect_result("post_rst", 32'd7, 32'd7, 1'b0, 1, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic against the scoreboard.
        acc = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
                in_b     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
                in_last  = ($urandom_range(0, 2) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_drained", exp_q.size(), 0);
        check("final_valid",   out_valid,    1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
